// File: rtl/atm_pkg.sv
// atm_pkg: shared types and helpers for the ATM transaction controller.
//   state_e : controller FSM states (3 bits, also exported on state_o)
//   err_e   : sticky error codes reported on err_code
//   bits_for / max_int : width helpers for counters sized from parameters
package atm_pkg;

    localparam int ST_W  = 3;
    localparam int ERR_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE        = 3'd0,
        PIN_WAIT    = 3'd1,
        AMT_WAIT    = 3'd2,
        DISPENSE    = 3'd3,
        EJECT       = 3'd4,
        RETAIN      = 3'd5,
        WAIT_REMOVE = 3'd6
    } state_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE    = 3'd0,
        ERR_PIN     = 3'd1,
        ERR_FUNDS   = 3'd2,
        ERR_ZERO    = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_CANCEL  = 3'd5
    } err_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the value n (at least 1).
    function automatic int bits_for(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/atm_if.sv
// atm_if: card/keypad front-end and dispenser signals of the ATM controller.
//   master : front-end side (drives card, PIN and amount inputs, observes results)
//   slave  : controller side (atm_ctrl)
interface atm_if #(
    parameter int PIN_W = 16,
    parameter int AMT_W = 16
) ();
    import atm_pkg::*;

    logic             card_inserted;
    logic [PIN_W-1:0] card_pin;
    logic [AMT_W-1:0] card_balance;
    logic             pin_valid;
    logic [PIN_W-1:0] pin_entry;
    logic             amt_valid;
    logic [AMT_W-1:0] amt_req;
    logic             cancel;
    logic             dispense_cash;
    logic [AMT_W-1:0] dispense_amt;
    logic [AMT_W-1:0] balance_o;
    logic             card_eject;
    logic             card_retain;
    logic [ERR_W-1:0] err_code;
    logic [ST_W-1:0]  state_o;

    modport master (
        output card_inserted, card_pin, card_balance, pin_valid, pin_entry,
               amt_valid, amt_req, cancel,
        input  dispense_cash, dispense_amt, balance_o, card_eject, card_retain,
               err_code, state_o
    );

    modport slave (
        input  card_inserted, card_pin, card_balance, pin_valid, pin_entry,
               amt_valid, amt_req, cancel,
        output dispense_cash, dispense_amt, balance_o, card_eject, card_retain,
               err_code, state_o
    );

endinterface

// File: rtl/atm_timer.sv
// atm_timer: loadable down-counter with a one-cycle expire flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : (re)start the count from load_val
//   load_val : cycles-minus-one until expire
//   expire   : high for one cycle, load_val+1 cycles after load
module atm_timer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic         expire
);
    logic [N-1:0] count_reg;
    logic         run_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            run_reg   <= 1'b0;
        end else if (load) begin
            count_reg <= load_val;
            run_reg   <= 1'b1;
        end else if (run_reg) begin
            if (count_reg == '0) begin
                run_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Flags the last counted cycle; run_reg drops right after, so it is a pulse.
    assign expire = run_reg && (count_reg == '0);

endmodule

// File: rtl/atm_ctrl.sv
// atm_ctrl: ATM transaction controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : atm_if.slave -- card/keypad inputs, dispenser/eject outputs,
//              sticky err_code and debug state_o. All outputs are registered.
module atm_ctrl
    import atm_pkg::*;
#(
    parameter int PIN_W       = 16,
    parameter int AMT_W       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 64,
    parameter int DISP_CYC    = 4
) (
    input  logic clk,
    input  logic rst,
    atm_if.slave bus
);
    localparam int TMR_W = bits_for(max_int(TIMEOUT_CYC, DISP_CYC));
    localparam int TRY_W = bits_for(MAX_TRIES);

    state_e           state_reg, state_next;
    err_e             err_reg, err_next;
    logic [PIN_W-1:0] pin_reg, pin_next;
    logic [AMT_W-1:0] balance_reg, balance_next;
    logic [AMT_W-1:0] dispense_amt_reg, dispense_amt_next;
    logic [TRY_W-1:0] tries_reg, tries_next;
    logic             dispense_cash_reg, card_eject_reg, card_retain_reg;
    logic             tmr_load, tmr_expire;
    logic [TMR_W-1:0] tmr_val;
    logic [TRY_W-1:0] tries_inc;

    // One timer serves both the idle timeout and the dispense duration:
    // the two are never needed in the same state.
    atm_timer #(.N(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign tries_inc = tries_reg + TRY_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            err_reg           <= ERR_NONE;
            pin_reg           <= '0;
            balance_reg       <= '0;
            dispense_amt_reg  <= '0;
            tries_reg         <= '0;
            dispense_cash_reg <= 1'b0;
            card_eject_reg    <= 1'b0;
            card_retain_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            err_reg           <= err_next;
            pin_reg           <= pin_next;
            balance_reg       <= balance_next;
            dispense_amt_reg  <= dispense_amt_next;
            tries_reg         <= tries_next;
            // Pulse/level outputs follow the state being entered, so they
            // line up exactly with the cycles spent in that state.
            dispense_cash_reg <= (state_next == DISPENSE);
            card_eject_reg    <= (state_next == EJECT);
            card_retain_reg   <= (state_next == RETAIN);
        end
    end

    always_comb begin
        state_next        = state_reg;
        err_next          = err_reg;
        pin_next          = pin_reg;
        balance_next      = balance_reg;
        dispense_amt_next = dispense_amt_reg;
        tries_next        = tries_reg;
        tmr_load          = 1'b0;
        tmr_val           = TMR_W'(TIMEOUT_CYC - 1);

        case (state_reg)
            IDLE: begin
                if (bus.card_inserted) begin
                    pin_next     = bus.card_pin;
                    balance_next = bus.card_balance;
                    tries_next   = '0;
                    err_next     = ERR_NONE;
                    tmr_load     = 1'b1;
                    state_next   = PIN_WAIT;
                end
            end

            PIN_WAIT: begin
                // Card pulled out: no eject pulse, straight back to IDLE.
                if (!bus.card_inserted) begin
                    err_next   = ERR_CANCEL;
                    state_next = IDLE;
                end else if (bus.cancel) begin
                    err_next   = ERR_CANCEL;
                    state_next = EJECT;
                end else if (bus.pin_valid) begin
                    if (bus.pin_entry == pin_reg) begin
                        tmr_load   = 1'b1;
                        state_next = AMT_WAIT;
                    end else begin
                        tries_next = tries_inc;
                        err_next   = ERR_PIN;
                        if (tries_inc == TRY_W'(MAX_TRIES)) begin
                            state_next = RETAIN;
                        end else begin
                            tmr_load = 1'b1;
                        end
                    end
                end else if (tmr_expire) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = EJECT;
                end
            end

            AMT_WAIT: begin
                if (!bus.card_inserted) begin
                    err_next   = ERR_CANCEL;
                    state_next = IDLE;
                end else if (bus.cancel) begin
                    err_next   = ERR_CANCEL;
                    state_next = EJECT;
                end else if (bus.amt_valid) begin
                    if (bus.amt_req == '0) begin
                        err_next = ERR_ZERO;
                        tmr_load = 1'b1;
                    end else if (bus.amt_req > balance_reg) begin
                        err_next = ERR_FUNDS;
                        tmr_load = 1'b1;
                    end else begin
                        // Compare above guarantees no underflow.
                        balance_next      = balance_reg - bus.amt_req;
                        dispense_amt_next = bus.amt_req;
                        tmr_val           = TMR_W'(DISP_CYC - 1);
                        tmr_load          = 1'b1;
                        state_next        = DISPENSE;
                    end
                end else if (tmr_expire) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = EJECT;
                end
            end

            DISPENSE: begin
                if (tmr_expire) begin
                    dispense_amt_next = '0;
                    state_next        = EJECT;
                end
            end

            EJECT:  state_next = WAIT_REMOVE;
            RETAIN: state_next = WAIT_REMOVE;

            WAIT_REMOVE: begin
                // Returning only on removal forces a fresh 0->1 insert edge.
                if (!bus.card_inserted) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.dispense_cash = dispense_cash_reg;
    assign bus.dispense_amt  = dispense_amt_reg;
    assign bus.balance_o     = balance_reg;
    assign bus.card_eject    = card_eject_reg;
    assign bus.card_retain   = card_retain_reg;
    assign bus.err_code      = err_reg;
    assign bus.state_o       = state_reg;

endmodule

// File: tb/tb_atm_ctrl.sv
// tb_atm_ctrl: directed, table-driven bench for atm_ctrl with default
// parameters (MAX_TRIES=3, TIMEOUT_CYC=64, DISP_CYC=4). Each table row holds
// the inputs for one clock edge and the outputs expected after that edge.
module tb_atm_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    atm_if #(.PIN_W(16), .AMT_W(16)) bus ();

    atm_ctrl #(
        .PIN_W(16), .AMT_W(16), .MAX_TRIES(3), .TIMEOUT_CYC(64), .DISP_CYC(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst, card;
        logic [15:0] cpin, cbal;
        logic        pv;
        logic [15:0] pe;
        logic        av;
        logic [15:0] ar;
        logic        cxl;
        logic [2:0]  st;
        logic        dc;
        logic [15:0] da, bal;
        logic        ej, rt;
        logic [2:0]  err;
    } vec_t;

    int errors = 0;
    int checks = 0;

    localparam int P = 'h1234;   // card PIN
    localparam int W = 'h0000;   // wrong PIN
    localparam int B = 500;      // card balance

    function automatic vec_t mk(input int rst_i, card, cpin, cbal, pv, pe, av, ar, cxl,
                                input int st, dc, da, bal, ej, rt, err);
        vec_t r;
        r.rst = 1'(rst_i); r.card = 1'(card); r.cpin = 16'(cpin); r.cbal = 16'(cbal);
        r.pv = 1'(pv); r.pe = 16'(pe); r.av = 1'(av); r.ar = 16'(ar); r.cxl = 1'(cxl);
        r.st = 3'(st); r.dc = 1'(dc); r.da = 16'(da); r.bal = 16'(bal);
        r.ej = 1'(ej); r.rt = 1'(rt); r.err = 3'(err);
        return r;
    endfunction

    task automatic clear_strobes();
        bus.pin_valid = 1'b0;
        bus.amt_valid = 1'b0;
        bus.cancel    = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one row at the falling edge, clock it, sample at the next falling edge.
    task automatic apply(input vec_t r, input string name);
        logic [40:0] act, exp;
        rst               = r.rst;
        bus.card_inserted = r.card;
        bus.card_pin      = r.cpin;
        bus.card_balance  = r.cbal;
        bus.pin_valid     = r.pv;
        bus.pin_entry     = r.pe;
        bus.amt_valid     = r.av;
        bus.amt_req       = r.ar;
        bus.cancel        = r.cxl;
        @(posedge clk);
        @(negedge clk);
        act = {bus.state_o, bus.dispense_cash, bus.dispense_amt, bus.balance_o,
               bus.card_eject, bus.card_retain, bus.err_code};
        exp = {r.st, r.dc, r.da, r.bal, r.ej, r.rt, r.err};
        checks++;
        $display("%s: state=%0d cash=%0b amt=%0d bal=%0d eject=%0b retain=%0b err=%0d",
                 name, bus.state_o, bus.dispense_cash, bus.dispense_amt, bus.balance_o,
                 bus.card_eject, bus.card_retain, bus.err_code);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st/cash/amt/bal/ej/rt/err=%0d/%0b/%0d/%0d/%0b/%0b/%0d, expected %0d/%0b/%0d/%0d/%0b/%0b/%0d",
                     name, bus.state_o, bus.dispense_cash, bus.dispense_amt, bus.balance_o,
                     bus.card_eject, bus.card_retain, bus.err_code,
                     r.st, r.dc, r.da, r.bal, r.ej, r.rt, r.err);
        end
        clear_strobes();
    endtask

    // Counts cycles (current one = 1) until card_eject, bounded.
    task automatic cycles_to_eject(output int n);
        n = 1;
        while (!bus.card_eject && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    vec_t tbl[$];
    int   n;

    initial begin
        bus.card_inserted = 1'b0;
        bus.card_pin      = '0;
        bus.card_balance  = '0;
        bus.pin_entry     = '0;
        bus.amt_req       = '0;
        clear_strobes();
        @(negedge clk);

        //               rst crd cpin cbal pv pe av ar  cx | st dc da  bal ej rt err
        tbl.push_back(mk(1, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   0,   0, 0, 0)); // reset
        // happy path
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 1, P, 0, 0,   0,   2, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 1, 200, 0,   3, 1, 200, 300, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   3, 1, 200, 300, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   3, 1, 200, 300, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   3, 1, 200, 300, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   4, 0, 0,   300, 1, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   6, 0, 0,   300, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   6, 0, 0,   300, 0, 0, 0)); // card left in
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   300, 0, 0, 0));
        // lockout
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   5, 0, 0,   500, 0, 1, 1));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   6, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   6, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   500, 0, 0, 1));
        // recovery, insufficient funds, exact-balance withdrawal
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, P, 0, 0,   0,   2, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 1, 600, 0,   2, 0, 0,   500, 0, 0, 2));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 1, 500, 0,   3, 1, 500, 0,   0, 0, 2));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   3, 1, 500, 0,   0, 0, 2));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   3, 1, 500, 0,   0, 0, 2));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   3, 1, 500, 0,   0, 0, 2));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   4, 0, 0,   0,   1, 0, 2));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   6, 0, 0,   0,   0, 0, 2));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   0,   0, 0, 2));
        // cancel beats a correct PIN; two earlier misses
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, P, 0, 0,   1,   4, 0, 0,   500, 1, 0, 5));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   6, 0, 0,   500, 0, 0, 5));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   500, 0, 0, 5));
        // re-insert: tries cleared, so two misses do not retain; cancel beats amt_valid
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, W, 0, 0,   0,   1, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 1, P, 0, 0,   0,   2, 0, 0,   500, 0, 0, 1));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 1, 100, 1,   4, 0, 0,   500, 1, 0, 5));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   6, 0, 0,   500, 0, 0, 5));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   500, 0, 0, 5));
        // amt strobe ignored in PIN_WAIT; card pulled in PIN_WAIT
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 1, 100, 0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   500, 0, 0, 5));
        // rst during dispense cycle 2
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   1, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 1, P, 0, 0,   0,   2, 0, 0,   500, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 1, 50,  0,   3, 1, 50,  450, 0, 0, 0));
        tbl.push_back(mk(0, 1, P, B, 0, 0, 0, 0,   0,   3, 1, 50,  450, 0, 0, 0));
        tbl.push_back(mk(1, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   0,   0, 0, 0));
        tbl.push_back(mk(0, 0, P, B, 0, 0, 0, 0,   0,   0, 0, 0,   0,   0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec %0d", i));

        // Timeout: eject lands on cycle 65 after the PIN strobe.
        apply(mk(0, 1, P, B, 0, 0, 0, 0, 0, 1, 0, 0, 500, 0, 0, 0), "to1 insert");
        apply(mk(0, 1, P, B, 1, P, 0, 0, 0, 2, 0, 0, 500, 0, 0, 0), "to1 pin");
        cycles_to_eject(n);
        chk("to1 eject cycle", n, 65);
        chk("to1 err", int'(bus.err_code), 4);
        chk("to1 state", int'(bus.state_o), 4);
        apply(mk(0, 0, P, B, 0, 0, 0, 0, 0, 6, 0, 0, 500, 0, 0, 4), "to1 remove");
        apply(mk(0, 0, P, B, 0, 0, 0, 0, 0, 0, 0, 0, 500, 0, 0, 4), "to1 idle");

        // Zero amount restarts the timer: eject 65 cycles after that strobe.
        apply(mk(0, 1, P, B, 0, 0, 0, 0, 0, 1, 0, 0, 500, 0, 0, 0), "to2 insert");
        apply(mk(0, 1, P, B, 1, P, 0, 0, 0, 2, 0, 0, 500, 0, 0, 0), "to2 pin");
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        apply(mk(0, 1, P, B, 0, 0, 1, 0, 0, 2, 0, 0, 500, 0, 0, 3), "to2 zero");
        cycles_to_eject(n);
        chk("to2 eject cycle", n, 65);
        chk("to2 err", int'(bus.err_code), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/atm_ctrl.md
Name: atm_ctrl

Overview:
Parametrised next-generation ATM transaction controller.
- Sequences card insert, PIN check with bounded retries and lockout, amount request, balance check, timed cash dispense, and card eject/retain.
- Tracks the session balance internally and has an inactivity timeout.
- Sits between the card/keypad front-end and the cash dispenser in the ATM subsystem.

Parameters:
PIN_W, 16, PIN width in bits
AMT_W, 16, amount/balance width in bits
MAX_TRIES, 3, wrong PINs allowed before the card is retained (≥1)
TIMEOUT_CYC, 64, idle cycles allowed in PIN_WAIT/AMT_WAIT before auto-eject
DISP_CYC, 4, cycles dispense_cash stays high per withdrawal

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
card_inserted  in  1  card present level
card_pin  in  PIN_W  stored PIN read from card, sampled on insert
card_balance  in  AMT_W  account balance, sampled on insert
pin_valid  in  1  one-cycle strobe, pin_entry is valid
pin_entry  in  PIN_W  keyed PIN
amt_valid  in  1  one-cycle strobe, amt_req is valid
amt_req  in  AMT_W  requested withdrawal
cancel  in  1  user abort
dispense_cash  out  1  dispenser enable
dispense_amt  out  AMT_W  amount being dispensed
balance_o  out  AMT_W  session balance register
card_eject  out  1  one-cycle eject pulse
card_retain  out  1  one-cycle retain (swallow) pulse
err_code  out  3  last error (atm_pkg::err_e), sticky until next insert
state_o  out  3  current state, for debug

Behaviour:
- All outputs registered. On rst: state IDLE; dispense_cash=0, dispense_amt=0, balance_o=0, card_eject=0, card_retain=0, err_code=ERR_NONE, try counter=0, timer idle. rst mid-transaction aborts immediately with no eject pulse.
- IDLE: on card_inserted=1, latch card_pin and card_balance into balance_o, clear tries and err_code, load timer, go to PIN_WAIT on the next edge.
- PIN_WAIT, on pin_valid:
  - match: go to AMT_WAIT, reload timer.
  - mismatch: tries+1 and err_code=ERR_PIN. If tries reaches MAX_TRIES, go to RETAIN; else stay and reload timer.
- AMT_WAIT, on amt_valid:
  - amt_req==0: err_code=ERR_ZERO, stay, reload timer.
  - amt_req>balance_o: err_code=ERR_FUNDS, stay, reload timer.
  - otherwise: balance_o<=balance_o-amt_req and dispense_amt<=amt_req in the same edge, go to DISPENSE.
  - The subtraction is unsigned AMT_W and cannot underflow because of the compare.
- DISPENSE: dispense_cash=1 for exactly DISP_CYC cycles, starting the cycle after amt_valid. Then dispense_amt clears to 0 and the state goes to EJECT. cancel and timeout are ignored here.
- EJECT: card_eject=1 for one cycle, then WAIT_REMOVE.
- RETAIN: card_retain=1 for one cycle, then WAIT_REMOVE. The card is considered swallowed.
- WAIT_REMOVE: stay until card_inserted=0, then IDLE. A new session never starts without a 0→1 insert edge.
- Timeout: in PIN_WAIT/AMT_WAIT, timer expiry after TIMEOUT_CYC cycles with no strobe sets err_code=ERR_TIMEOUT and goes to EJECT.
- cancel in PIN_WAIT/AMT_WAIT sets err_code=ERR_CANCEL and goes to EJECT.
- Priority when events coincide in one cycle: cancel > pin_valid/amt_valid > timeout.
- card_inserted dropping in PIN_WAIT/AMT_WAIT sets err_code=ERR_CANCEL and goes to IDLE with no eject pulse.
- Strobes are ignored outside their own state.

Decomposition:
- Package atm_pkg holds:
  - state_e enum: IDLE, PIN_WAIT, AMT_WAIT, DISPENSE, EJECT, RETAIN, WAIT_REMOVE (3 bits).
  - err_e enum: ERR_NONE, ERR_PIN, ERR_FUNDS, ERR_ZERO, ERR_TIMEOUT, ERR_CANCEL.
  - Width helper constants.
- Sub-module atm_timer: down-counter with load, parameter N, and a one-cycle expire output. Shared by the timeout and the dispense duration.

Test Plan:
1. Happy path, MAX_TRIES=3, DISP_CYC=4: insert, card_balance=500, card_pin=0x1234, pin_entry=0x1234, amt_req=200 -> dispense_cash high 4 cycles, dispense_amt=200, balance_o=300, one card_eject pulse, err_code=ERR_NONE.
2. Lockout: three pin_entry=0x0000 strobes -> err_code=ERR_PIN after the first, card_retain pulse after the third, no card_eject, state_o=WAIT_REMOVE until the card is removed.
3. Recovery: two wrong PINs then the correct one, then amt_req=600 with balance 500 -> err_code=ERR_FUNDS, stay in AMT_WAIT; then amt_req=500 -> dispense, balance_o=0.
4. Timeout, TIMEOUT_CYC=64: correct PIN then no amt_valid -> card_eject on cycle 65 after the PIN, err_code=ERR_TIMEOUT. A second run with amt_req=0 -> err_code=ERR_ZERO and the timer restarts.
5. Simultaneous and abort: cancel and amt_valid in the same cycle -> cancel wins, no dispense, eject. rst asserted during DISPENSE cycle 2 -> all outputs reset on the next edge.
6. Re-entry: leave card_inserted high after eject -> no new session. Drop, then re-insert -> PIN_WAIT with tries cleared.
